mig7_ui_bridge: RTL and testbench

Request-to-MIG bridge sitting between the node's memory clients and the MIG7 DDR3 controller user interface, in the `clk_ram` (MIG `ui_clk`) domain. It converts a single valid/ready request stream (write or read, one 128-bit beat each) into correctly sequenced `app_*` command and write-data handshakes. It returns read data through a credit-limited FIFO so that downstream backpressure can never lose MIG read data. It is a drop-in replacement for the MIG stub at the MIG user port.

---
 rtl/mig7_ui_bridge_if.sv | 56 +++++
 rtl/mig7_ui_bridge.sv | 147 ++++++++++++++
 tb/tb_mig7_ui_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig7_ui_bridge_if.sv
// Client request/response stream and MIG7 user-interface signals for mig7_ui_bridge.
// The slave modport is the bridge; the master modport is the client + MIG side.
interface mig7_ui_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128
);
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [MASK_WIDTH-1:0] req_mask;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0] app_addr;
  logic [2:0]            app_cmd;
  logic                  app_en;
  logic [DATA_WIDTH-1:0] app_wdf_data;
  logic                  app_wdf_end;
  logic [MASK_WIDTH-1:0] app_wdf_mask;
  logic                  app_wdf_wren;
  logic                  app_rdy;
  logic                  app_wdf_rdy;
  logic [DATA_WIDTH-1:0] app_rd_data;
  logic                  app_rd_data_valid;
  logic                  app_rd_data_end;
  logic                  app_sr_active;
  logic                  app_ref_ack;
  logic                  app_zq_ack;
  logic                  app_sr_req;
  logic                  app_ref_req;
  logic                  app_zq_req;

  modport slave (
    input  req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack,
    output req_ready, rsp_valid, rsp_data,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask,
           app_wdf_wren, app_sr_req, app_ref_req, app_zq_req
  );

  modport master (
    output req_valid, req_wr, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack,
    input  req_ready, rsp_valid, rsp_data,
           app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask,
           app_wdf_wren, app_sr_req, app_ref_req, app_zq_req
  );
endinterface

// File: rtl/mig7_ui_bridge.sv
// Request-stream to MIG7 user-interface bridge with a credit-limited
// first-word-fall-through read-return FIFO.
module mig7_ui_bridge #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RD_DEPTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           init_calib_complete,
  mig7_ui_bridge_if.slave                bus,
  output logic [$clog2(RD_DEPTH+1)-1:0]  rd_pending,
  output logic                           rd_overflow
);
  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PW         = $clog2(RD_DEPTH + 1);
  localparam int unsigned AW         = $clog2(RD_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e                state_q, state_d;
  logic                  app_en_q, app_en_d;
  logic                  wren_q, wren_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         wptr_q, rptr_q;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] mem_q [RD_DEPTH];

  logic credit_ok, accept, rd_accept, fifo_full, fifo_empty, push, pop;

  assign credit_ok     = pend_q < PW'(RD_DEPTH);
  assign bus.req_ready = rst && (state_q == IDLE) && init_calib_complete
                         && (bus.req_wr || credit_ok);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_wr;
  assign fifo_full     = cnt_q == PW'(RD_DEPTH);
  assign fifo_empty    = cnt_q == '0;
  assign push          = bus.app_rd_data_valid && !fifo_full;
  assign pop           = !fifo_empty && bus.rsp_ready;

  // Command sequencing: command and write-data handshakes retire independently.
  always_comb begin
    state_d  = state_q;
    app_en_d = app_en_q;
    wren_d   = wren_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d   = bus.req_addr;
          app_en_d = 1'b1;
          if (bus.req_wr) begin
            cmd_d   = 3'b000;
            wdata_d = bus.req_data;
            wmask_d = bus.req_mask;
            wren_d  = 1'b1;
            state_d = WRITE;
          end else begin
            cmd_d   = 3'b001;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (app_en_q && bus.app_rdy)     app_en_d = 1'b0;
        if (wren_q && bus.app_wdf_rdy)   wren_d   = 1'b0;
        if ((!app_en_q || bus.app_rdy) && (!wren_q || bus.app_wdf_rdy)) state_d = IDLE;
      end
      READ: begin
        if (bus.app_rdy) begin
          app_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits cover every read from accept until its response is consumed.
  always_comb begin
    pend_d = pend_q + PW'(rd_accept) - PW'(pop);
    cnt_d  = cnt_q + PW'(push) - PW'(pop);
    ovf_d  = ovf_q || (bus.app_rd_data_valid && fifo_full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      app_en_q <= 1'b0;
      wren_q   <= 1'b0;
      cmd_q    <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      app_en_q <= app_en_d;
      wren_q   <= wren_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.app_rd_data;
  end

  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_wren = wren_q;
  assign bus.app_wdf_end  = wren_q;
  assign bus.app_cmd      = cmd_q;
  assign bus.app_addr     = addr_q;
  assign bus.app_wdf_data = wdata_q;
  assign bus.app_wdf_mask = wmask_q;
  assign bus.app_sr_req   = 1'b0;
  assign bus.app_ref_req  = 1'b0;
  assign bus.app_zq_req   = 1'b0;
  assign bus.rsp_valid    = !fifo_empty;
  assign bus.rsp_data     = mem_q[rptr_q];
  assign rd_pending       = pend_q;
  assign rd_overflow      = ovf_q;

  logic unused_status;
  assign unused_status = &{1'b0, bus.app_rd_data_end, bus.app_sr_active,
                           bus.app_ref_ack, bus.app_zq_ack};
endmodule

// File: tb/tb_mig7_ui_bridge.sv
// Randomized bench for mig7_ui_bridge: a transaction-level model of the bridge
// plus a simple in-order MIG memory model, compared against the DUT every cycle.
module tb_mig7_ui_bridge;
  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned MW = 16;
  localparam int          RD = 16;
  localparam int unsigned PW = 5;

  logic          clk;
  logic          rst;
  logic          calib;
  logic [PW-1:0] rd_pending;
  logic          rd_overflow;

  mig7_ui_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mig7_ui_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(RD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (calib),
    .bus                 (bus),
    .rd_pending          (rd_pending),
    .rd_overflow         (rd_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state
  bit          m_busy, m_en, m_wdf, m_ovf;
  logic [2:0]  m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [MW-1:0] m_mask;
  int          m_pend;
  logic [DW-1:0] m_fifo[$];

  typedef struct { int due; logic [DW-1:0] d; } ret_t;
  ret_t          sched[$];
  int            last_due;
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            cyc;

  int p_valid, p_wr, p_rdy, p_wdf, p_rsp, p_calib, lat_min, lat_max;
  bit force_rd;
  int en_hi, wren_hi, acc_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {32'(a) * 32'h9E37_79B1, ~32'(a), 32'hC0DE_0000 | 32'(a), 32'(a) + 32'h1234};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_en = 0; m_wdf = 0; m_ovf = 0;
    m_cmd = '0; m_addr = '0; m_data = '0; m_mask = '0;
    m_pend = 0;
    m_fifo.delete();
    sched.delete();
    last_due = 0;
  endtask

  function automatic bit model_ready();
    return rst && !m_busy && calib && (bus.req_wr || m_pend < RD);
  endfunction

  task automatic idle_in();
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_data = '0; bus.req_mask = '0;
    bus.rsp_ready = 0; bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    calib = 1; force_rd = 0;
  endtask

  task automatic rand_inputs();
    bus.req_valid   = pct(p_valid);
    bus.req_wr      = pct(p_wr);
    bus.req_addr    = AW'($urandom_range(31, 0)) << 3;
    bus.req_data    = {$urandom, $urandom, $urandom, $urandom};
    bus.req_mask    = pct(30) ? MW'($urandom) : '0;
    bus.rsp_ready   = pct(p_rsp);
    bus.app_rdy     = pct(p_rdy);
    bus.app_wdf_rdy = pct(p_wdf);
    calib           = pct(p_calib);
  endtask

  task automatic compare();
    chk("req_ready",    bus.req_ready,    model_ready());
    chk("app_en",       bus.app_en,       m_en);
    chk("app_wdf_wren", bus.app_wdf_wren, m_wdf);
    chk("app_wdf_end",  bus.app_wdf_end,  m_wdf);
    chk("app_cmd",      bus.app_cmd,      m_cmd);
    chk("app_addr",     bus.app_addr,     m_addr);
    chk("app_wdf_data", bus.app_wdf_data, m_data);
    chk("app_wdf_mask", bus.app_wdf_mask, m_mask);
    chk("rsp_valid",    bus.rsp_valid,    m_fifo.size() > 0);
    if (m_fifo.size() > 0) chk("rsp_data", bus.rsp_data, m_fifo[0]);
    chk("rd_pending",   rd_pending,       m_pend);
    chk("rd_overflow",  rd_overflow,      m_ovf);
    chk("maint_reqs",   {bus.app_sr_req, bus.app_ref_req, bus.app_zq_req}, 3'b000);
    en_hi   += int'(bus.app_en);
    wren_hi += int'(bus.app_wdf_wren);
  endtask

  // Advance the model across the upcoming rising edge using the driven inputs.
  task automatic update();
    bit acc, en_hs, wdf_hs, pop, full;
    int due;
    logic [DW-1:0] cur;
    if (!rst) begin
      model_reset();
      return;
    end
    acc    = bus.req_valid && model_ready();
    en_hs  = m_en && bus.app_rdy;
    wdf_hs = m_wdf && bus.app_wdf_rdy;
    if (wdf_hs) begin
      cur = mem_rd(m_addr);
      for (int b = 0; b < MW; b++)
        if (!m_mask[b]) cur[b*8 +: 8] = m_data[b*8 +: 8];
      mem[m_addr] = cur;
    end
    if (en_hs && m_cmd == 3'b001) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      sched.push_back('{due, mem_rd(m_addr)});
      last_due = due;
    end
    if (m_busy) begin
      if (en_hs)  m_en  = 0;
      if (wdf_hs) m_wdf = 0;
      if (!m_en && !m_wdf) m_busy = 0;
    end
    full = m_fifo.size() == RD;
    pop  = bus.rsp_ready && m_fifo.size() > 0;
    if (pop) void'(m_fifo.pop_front());
    if (bus.app_rd_data_valid) begin
      if (full) m_ovf = 1;
      else      m_fifo.push_back(bus.app_rd_data);
    end
    m_pend += int'(acc && !bus.req_wr) - int'(pop);
    if (acc) begin
      acc_cnt++;
      m_busy = 1; m_en = 1; m_wdf = bus.req_wr;
      m_addr = bus.req_addr;
      m_cmd  = bus.req_wr ? 3'b000 : 3'b001;
      if (bus.req_wr) begin
        m_data = bus.req_data;
        m_mask = bus.req_mask;
      end
    end
  endtask

  // Called at a falling edge with the inputs for the coming rising edge already set.
  task automatic step();
    bus.app_rd_data_valid = 0;
    bus.app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
    if (force_rd) begin
      bus.app_rd_data_valid = 1;
    end else if (rst && sched.size() > 0 && sched[0].due <= cyc) begin
      bus.app_rd_data_valid = 1;
      bus.app_rd_data       = sched[0].d;
      void'(sched.pop_front());
    end
    bus.app_rd_data_end = bus.app_rd_data_valid;
    #1;
    compare();
    update();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    en_hi = 0; wren_hi = 0; acc_cnt = 0;
    lat_min = 3; lat_max = 3;
    bus.app_sr_active = 0; bus.app_ref_ack = 0; bus.app_zq_ack = 0;
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0; bus.app_rd_data = '0;
    model_reset();
    idle_in();
    rst = 0;
    @(negedge clk);
    repeat (3) step();
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_app_en", bus.app_en, 0);
    chk("reset_pending", rd_pending, 0);
    rst = 1;
    step();

    // Write with no stall
    idle_in();
    bus.req_valid = 1; bus.req_wr = 1; bus.req_addr = 28'h0000100;
    bus.req_data = {16{8'hA5}}; bus.req_mask = '0;
    #1 chk("wr_accept_ready", bus.req_ready, 1);
    step();
    idle_in(); en_hi = 0; wren_hi = 0;
    #1;
    chk("wr_cmd", bus.app_cmd, 3'b000);
    chk("wr_end", bus.app_wdf_end, 1);
    chk("wr_addr", bus.app_addr, 28'h0000100);
    chk("wr_data", bus.app_wdf_data, {16{8'hA5}});
    step();
    #1 chk("wr_ready_back", bus.req_ready, 1);
    step(); step();
    chk("wr_en_cycles", en_hi, 1);
    chk("wr_wren_cycles", wren_hi, 1);

    // Split write: data accepted at once, command stalled five cycles
    idle_in();
    bus.req_valid = 1; bus.req_wr = 1; bus.req_addr = 28'h0000200;
    bus.req_data = {$urandom, $urandom, $urandom, $urandom}; bus.req_mask = 16'h00F0;
    step();
    idle_in(); bus.app_rdy = 0; en_hi = 0; wren_hi = 0;
    repeat (5) begin
      #1;
      chk("split_addr", bus.app_addr, 28'h0000200);
      chk("split_ready", bus.req_ready, 0);
      step();
    end
    bus.app_rdy = 1;
    step();
    idle_in();
    #1 chk("split_ready_back", bus.req_ready, 1);
    step();
    chk("split_en_cycles", en_hi, 6);
    chk("split_wren_cycles", wren_hi, 1);

    // Read credit limit with a 20-cycle MIG latency and no consumer
    lat_min = 20; lat_max = 20; acc_cnt = 0;
    for (int i = 0; i < 200 && acc_cnt < 16; i++) begin
      idle_in(); bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = AW'(i) << 3;
      step();
    end
    chk("credit_accepts", acc_cnt, 16);
    chk("credit_pending", rd_pending, 16);
    idle_in();
    step();
    bus.req_valid = 1; bus.req_wr = 0;
    #1 chk("credit_block_read", bus.req_ready, 0);
    bus.req_wr = 1; bus.req_addr = 28'h0000300;
    #1 chk("credit_write_ok", bus.req_ready, 1);
    step();
    idle_in();
    repeat (40) step();
    chk("fifo_full_valid", bus.rsp_valid, 1);

    // Forced overflow with the FIFO full
    force_rd = 1;
    step();
    force_rd = 0;
    chk("overflow_set", rd_overflow, 1);
    bus.rsp_ready = 1;
    repeat (20) step();
    chk("overflow_sticky", rd_overflow, 1);
    chk("credit_drained", rd_pending, 0);

    // Accept and pop in the same cycle at rd_pending = 5
    lat_min = 2; lat_max = 2; acc_cnt = 0;
    for (int i = 0; i < 50 && acc_cnt < 5; i++) begin
      idle_in(); bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = AW'(i + 40) << 3;
      step();
    end
    idle_in();
    repeat (10) step();
    #1 chk("pend5_before", rd_pending, 5);
    bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = 28'h0000040; bus.rsp_ready = 1;
    #1 chk("pend5_ready", bus.req_ready, 1);
    step();
    idle_in();
    chk("accept_pop_pending", rd_pending, 5);
    bus.rsp_ready = 1;
    repeat (20) step();
    chk("pend5_drained", rd_pending, 0);

    // Calibration gating
    idle_in(); calib = 0; bus.req_valid = 1; bus.req_wr = 1;
    #1 chk("calib_gate_wr", bus.req_ready, 0);
    step();
    bus.req_wr = 0;
    #1 chk("calib_gate_rd", bus.req_ready, 0);
    step();

    // Reset in the middle of a stalled write with reads outstanding
    acc_cnt = 0;
    for (int i = 0; i < 20 && acc_cnt < 2; i++) begin
      idle_in(); bus.req_valid = 1; bus.req_wr = 0; bus.req_addr = AW'(i) << 3;
      step();
    end
    idle_in();
    step();
    bus.req_valid = 1; bus.req_wr = 1; bus.req_addr = 28'h0000500;
    bus.req_data = {4{32'hDEAD_BEEF}};
    bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    step();
    idle_in(); bus.app_rdy = 0; bus.app_wdf_rdy = 0;
    step();
    chk("rst_pre_en", bus.app_en, 1);
    chk("rst_pre_pending", rd_pending, 2);
    rst = 0;
    model_reset();
    #1;
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_app_wren", bus.app_wdf_wren, 0);
    chk("rst_pending", rd_pending, 0);
    chk("rst_overflow", rd_overflow, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    step(); step();
    rst = 1; idle_in();
    step();

    // Randomized traffic
    p_valid = 60; p_wr = 50; p_rdy = 70; p_wdf = 70; p_rsp = 60; p_calib = 95;
    lat_min = 1; lat_max = 20;
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end
    idle_in(); bus.rsp_ready = 1;
    for (int i = 0; i < 500 && (m_busy || m_pend != 0 || m_fifo.size() != 0); i++) step();
    #1;
    chk("final_pending", rd_pending, 0);
    chk("final_rsp_valid", bus.rsp_valid, 0);
    chk("final_overflow", rd_overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
